// File: rtl/uart_tx_buffered_if.sv
// Byte handshake into the UART transmitter.
//   tx_data  : byte to transmit
//   tx_valid : tx_data is valid this cycle
//   tx_ready : transmitter FIFO can accept a byte this cycle
// A byte transfers on a rising clock edge where tx_valid && tx_ready.
interface uart_tx_buffered_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter.
// Bytes arrive over a valid/ready handshake into a small FIFO and are
// serialised LSB-first onto uart_txd (1 start, 8 data, 1 stop, no parity).
// Ports:
//   sys_clk    : system clock, rising edge
//   sys_rst_n  : asynchronous reset, active-low
//   tx_if      : byte handshake (tx_data, tx_valid in; tx_ready out)
//   uart_txd   : serial line, idle high, driven from a flop
//   tx_busy    : a frame is in progress or the FIFO is non-empty
//   fifo_count : current FIFO occupancy
module uart_tx_buffered #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    uart_tx_buffered_if.slave           tx_if,
    output logic                        uart_txd,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int BW      = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BPS_CNT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          baud_end;
    logic          fifo_empty;

    assign tx_if.tx_ready = (fifo_count < DEPTH_C);
    assign fifo_empty     = (fifo_count == '0);
    assign baud_end       = (baud_cnt == BAUD_LAST);
    assign push           = tx_if.tx_valid && tx_if.tx_ready;
    assign tx_busy        = (state != IDLE) || !fifo_empty;

    // The FSM consumes a byte either straight from IDLE or at the last
    // cycle of STOP, which chains frames without an idle gap.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            pop = (state == IDLE) || ((state == STOP) && baud_end);
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_if.tx_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // uart_txd is registered from the current state, so the line lags the
    // state by one cycle; every symbol is still exactly BPS_CNT cycles wide.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_txd <= 1'b1;
        end else begin
            baud_cnt <= ((state == IDLE) || baud_end) ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= START;
                    end
                end
                START: begin
                    uart_txd <= 1'b0;
                    if (baud_end) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    uart_txd <= shift[bit_idx];
                    if (baud_end) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    uart_txd <= 1'b1;
                    if (baud_end) begin
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered with BPS_CNT=10, FIFO_DEPTH=4.
// Accepted bytes go into a scoreboard queue; a frame monitor decodes
// uart_txd, checks every sample of each frame against the queue head.
module tb_uart_tx_buffered;
    localparam int FD = 4;

    logic           sys_clk = 1'b0;
    logic           sys_rst_n = 1'b0;
    logic           uart_txd;
    logic           tx_busy;
    logic [2:0]     fifo_count;

    uart_tx_buffered_if bus();

    uart_tx_buffered #(
        .CLK_FREQ   (1_000_000),
        .UART_BPS   (100_000),
        .FIFO_DEPTH (FD)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .tx_if      (bus),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] sb[$];
    int         frame_starts[$];
    logic       mon_en = 1'b0;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Frame monitor: runs forever, forked from the main initial block.
    task automatic monitor();
        int         cnt = 0;
        int         bad = 0;
        bit         active = 0;
        bit         have_exp = 0;
        logic [7:0] exp_b = '0;
        logic [7:0] cap = '0;
        logic       exp_bit;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n || !mon_en) begin
                active = 0;
            end else if (!active) begin
                if (uart_txd === 1'b0) begin
                    active   = 1;
                    cnt      = 0;
                    bad      = 0;
                    cap      = '0;
                    have_exp = (sb.size() != 0);
                    exp_b    = have_exp ? sb[0] : 8'h00;
                    frame_starts.push_back(cyc);
                end
            end else begin
                cnt++;
            end
            if (active) begin
                if (cnt < 10)      exp_bit = 1'b0;
                else if (cnt < 90) exp_bit = exp_b[(cnt - 10) / 10];
                else               exp_bit = 1'b1;
                if (uart_txd !== exp_bit) bad++;
                if (cnt >= 10 && cnt < 90 && (cnt % 10) == 5) cap[(cnt - 10) / 10] = uart_txd;
                if (cnt == 99) begin
                    active = 0;
                    vectors++;
                    if (!have_exp) begin
                        miscompares++;
                        $display("FAIL frame_unexpected: got byte %h, required no frame", cap);
                    end else begin
                        void'(sb.pop_front());
                        if (bad != 0 || cap !== exp_b) begin
                            miscompares++;
                            $display("FAIL frame: got byte %h with %0d bad samples, required %h with 0",
                                     cap, bad, exp_b);
                        end
                    end
                end
            end
        end
    endtask

    // Called at a negedge; leaves tx_valid high and returns at the negedge
    // after the accepting edge.
    task automatic drive_byte(input logic [7:0] d, output int acc_edge);
        int waited = 0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        while (bus.tx_ready !== 1'b1 && waited < 2000) begin
            @(negedge sys_clk);
            waited++;
        end
        if (bus.tx_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: tx_ready=%b after %0d cycles, required 1", bus.tx_ready, waited);
            acc_edge = -1;
        end else begin
            acc_edge = cyc + 1;
            sb.push_back(d);
            @(negedge sys_clk);
        end
    endtask

    task automatic wait_idle(input int limit, output int fall_cyc);
        int n = 0;
        while (tx_busy !== 1'b0 && n < limit) begin
            @(negedge sys_clk);
            n++;
        end
        fall_cyc = cyc;
        vectors++;
        if (tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_timeout: tx_busy=%b after %0d cycles, required 0", tx_busy, n);
        end
    endtask

    task automatic run_len(input logic lvl, output int len);
        len = 0;
        while (uart_txd === lvl && len < 200) begin
            @(negedge sys_clk);
            len++;
        end
    endtask

    task automatic settle_and_check_drain(input string name);
        repeat (3) @(negedge sys_clk);
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d bytes never framed, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        sys_rst_n    = 1'b0;
        repeat (3) @(negedge sys_clk);
        vectors++; if (uart_txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b, required 1", uart_txd); end
        vectors++; if (bus.tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, required 1", bus.tx_ready); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", tx_busy); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
        sys_rst_n = 1'b1;
        mon_en    = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || bus.tx_ready !== 1'b1) bad++;
            @(negedge sys_clk);
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL idle_line: %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_single();
        int n;
        int fall;
        frame_starts.delete();
        drive_byte(8'hA5, n);
        bus.tx_valid = 1'b0;
        vectors++; if (uart_txd !== 1'b1) begin miscompares++; $display("FAIL single_txd_n: got %b, required 1", uart_txd); end
        @(negedge sys_clk);
        vectors++; if (uart_txd !== 1'b1) begin miscompares++; $display("FAIL single_txd_n1: got %b, required 1", uart_txd); end
        vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b, required 1", tx_busy); end
        @(negedge sys_clk);
        vectors++; if (uart_txd !== 1'b0) begin miscompares++; $display("FAIL single_txd_n2: got %b, required 0", uart_txd); end
        wait_idle(300, fall);
        vectors++; if (fall !== n + 101) begin miscompares++; $display("FAIL single_busy_fall: got edge %0d, required %0d", fall, n + 101); end
        settle_and_check_drain("single");
        vectors++; if (frame_starts.size() !== 1) begin miscompares++; $display("FAIL single_frames: got %0d, required 1", frame_starts.size()); end
    endtask

    task automatic test_fill();
        int e1;
        int e;
        int fall;
        frame_starts.delete();
        drive_byte(8'h01, e1);
        for (int b = 2; b <= 5; b++) drive_byte(8'(b), e);
        vectors++; if (e !== e1 + 4) begin miscompares++; $display("FAIL fill_accept5: got edge %0d, required %0d", e, e1 + 4); end
        vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL fill_count: got %0d, required 4", fifo_count); end
        vectors++; if (bus.tx_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready: got %b, required 0", bus.tx_ready); end
        drive_byte(8'h06, e);
        bus.tx_valid = 1'b0;
        vectors++; if (e !== e1 + 102) begin miscompares++; $display("FAIL fill_accept6: got edge %0d, required %0d", e, e1 + 102); end
        wait_idle(1000, fall);
        settle_and_check_drain("fill");
        vectors++;
        if (frame_starts.size() !== 6) begin
            miscompares++;
            $display("FAIL fill_frames: got %0d, required 6", frame_starts.size());
        end else begin
            for (int i = 1; i < 6; i++) begin
                vectors++;
                if (frame_starts[i] - frame_starts[i-1] !== 100) begin
                    miscompares++;
                    $display("FAIL fill_pitch: got %0d, required 100", frame_starts[i] - frame_starts[i-1]);
                end
            end
        end
    endtask

    task automatic test_simul();
        int ea;
        int e;
        int fall;
        drive_byte(8'h11, ea);
        drive_byte(8'h22, e);
        drive_byte(8'h33, e);
        bus.tx_valid = 1'b0;
        while (cyc < ea + 100) @(negedge sys_clk);
        vectors++; if (fifo_count !== 3'd2) begin miscompares++; $display("FAIL simul_pre_count: got %0d, required 2", fifo_count); end
        drive_byte(8'h3C, e);
        bus.tx_valid = 1'b0;
        vectors++; if (e !== ea + 101) begin miscompares++; $display("FAIL simul_edge: got edge %0d, required %0d", e, ea + 101); end
        vectors++; if (fifo_count !== 3'd2) begin miscompares++; $display("FAIL simul_count: got %0d, required 2", fifo_count); end
        wait_idle(1000, fall);
        settle_and_check_drain("simul");
    endtask

    task automatic test_back_to_back();
        int e;
        int n = 0;
        int len;
        int fall;
        frame_starts.delete();
        drive_byte(8'h00, e);
        drive_byte(8'hFF, e);
        bus.tx_valid = 1'b0;
        while (uart_txd !== 1'b0 && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        run_len(1'b0, len);
        vectors++; if (len !== 90) begin miscompares++; $display("FAIL b2b_low00: got %0d cycles, required 90", len); end
        run_len(1'b1, len);
        vectors++; if (len !== 10) begin miscompares++; $display("FAIL b2b_stop: got %0d cycles, required 10", len); end
        run_len(1'b0, len);
        vectors++; if (len !== 10) begin miscompares++; $display("FAIL b2b_startFF: got %0d cycles, required 10", len); end
        wait_idle(500, fall);
        settle_and_check_drain("b2b");
        vectors++;
        if (frame_starts.size() !== 2) begin
            miscompares++;
            $display("FAIL b2b_frames: got %0d, required 2", frame_starts.size());
        end else begin
            vectors++;
            if (frame_starts[1] - frame_starts[0] !== 100) begin
                miscompares++;
                $display("FAIL b2b_pitch: got %0d, required 100", frame_starts[1] - frame_starts[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int e;
        int x;
        int fall;
        drive_byte(8'h00, e);
        drive_byte(8'h77, x);
        drive_byte(8'h88, x);
        bus.tx_valid = 1'b0;
        while (cyc < e + 46) @(negedge sys_clk);
        vectors++; if (uart_txd !== 1'b0) begin miscompares++; $display("FAIL rmid_bit3: got %b, required 0", uart_txd); end
        mon_en = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1;
        vectors++; if (uart_txd !== 1'b1) begin miscompares++; $display("FAIL rmid_txd: got %b, required 1", uart_txd); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL rmid_count: got %0d, required 0", fifo_count); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b, required 0", tx_busy); end
        sb.delete();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        mon_en    = 1'b1;
        frame_starts.delete();
        @(negedge sys_clk);
        drive_byte(8'hFF, e);
        bus.tx_valid = 1'b0;
        wait_idle(500, fall);
        vectors++; if (fall !== e + 101) begin miscompares++; $display("FAIL rmid_busy_fall: got edge %0d, required %0d", fall, e + 101); end
        repeat (50) @(negedge sys_clk);
        settle_and_check_drain("rmid");
        vectors++; if (frame_starts.size() !== 1) begin miscompares++; $display("FAIL rmid_frames: got %0d, required 1", frame_starts.size()); end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_idle();
        test_single();
        test_fill();
        test_simul();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
